// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between a pipeline stage register and its neighbours.
// Pure wiring, no latency of its own.
// Backpressure: in_ready/out_ready carry the stall in each direction.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // Environment side: drives upstream payload, flush and downstream ready.
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Stage side: the register itself.
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a 2-entry skid buffer and a flush that inserts a CLEAR_VAL bubble.
// Latency: 1 cycle from accepted input to out_valid/out_data; one item per cycle when streaming.
// Backpressure: in_ready is registered (!skid_valid); a stalled stage absorbs one extra item in the skid entry.
// Optional statistics counters (stall_cnt, flush_cnt) exist only when PIPE_STAGE_REG_STATS_EN is defined.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    pipe_stage_reg_if.slave   pipe
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Bit 0 is main_valid, bit 1 is skid_valid, so the outputs come straight off the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    assign pipe.out_valid = state[0];
    assign pipe.in_ready  = ~state[1];
    assign pipe.out_data  = main_data;

    // Occupancy FSM and payload registers; reset beats flush, flush beats every transfer.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= EMPTY;
            main_data <= CLEAR_VAL;
            skid_data <= CLEAR_VAL;
        end else if (pipe.flush) begin
            state     <= EMPTY;
            main_data <= CLEAR_VAL;
            skid_data <= CLEAR_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (pipe.in_valid) begin
                        state     <= FULL;
                        main_data <= pipe.in_data;
                    end
                end
                FULL: begin
                    if (pipe.out_ready) begin
                        if (pipe.in_valid) begin
                            main_data <= pipe.in_data;
                        end else begin
                            state <= EMPTY;
                        end
                    end else if (pipe.in_valid) begin
                        // Downstream stalled: park the new item, keep out_data steady.
                        state     <= SKID;
                        skid_data <= pipe.in_data;
                    end
                end
                SKID: begin
                    // in_ready is low here, so in_valid is deliberately ignored.
                    if (pipe.out_ready) begin
                        state     <= FULL;
                        main_data <= skid_data;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    // Saturating stall/flush counters; only reset clears them, a flush does not.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state[0] && !pipe.out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (pipe.flush && (state != EMPTY) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
